// File: rtl/ldpc_pkg.sv
// Shared widths, message types and helpers for the DG-LDPC check node datapath.
package ldpc_pkg;

  localparam int IN_W   = 10;
  localparam int OUT_W  = 6;
  localparam int MAXMAG = 2**(OUT_W-1) - 1;

  typedef logic signed [IN_W-1:0]  v2c_t;
  typedef logic signed [OUT_W-1:0] c2v_t;
  typedef logic        [OUT_W-2:0] mag_t;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} cnu_state_t;

  localparam mag_t             MAXMAG_M  = mag_t'(MAXMAG);
  localparam logic [IN_W-1:0]  MAXMAG_IN = IN_W'(MAXMAG);

  // The most negative input has no positive twin, so it folds to the largest positive value first.
  function automatic mag_t sat_mag(input v2c_t x);
    logic [IN_W-1:0] a;
    if (!x[IN_W-1])
      a = x;
    else if (x == {1'b1, {(IN_W-1){1'b0}}})
      a = {1'b0, {(IN_W-1){1'b1}}};
    else
      a = -x;
    if (a > MAXMAG_IN)
      return MAXMAG_M;
    return a[OUT_W-2:0];
  endfunction

  function automatic c2v_t apply_sign(input mag_t m, input logic s);
    c2v_t ext;
    ext = c2v_t'({1'b0, m});
    return s ? -ext : ext;
  endfunction

endpackage

// File: rtl/cnu_min_tracker.sv
// Running sign product, smallest two magnitudes and position of the smallest for one check row.
module cnu_min_tracker
  import ldpc_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             upd,
  input  mag_t             mag,
  input  logic             sign,
  input  logic [IDX_W-1:0] idx,
  output mag_t             min1,
  output mag_t             min2,
  output logic [IDX_W-1:0] idx1,
  output logic             sgn_tot,
  output mag_t             nxt_min1,
  output mag_t             nxt_min2,
  output logic [IDX_W-1:0] nxt_idx1,
  output logic             nxt_sgn
);

  // Strict compares keep the first minimum on ties, so equal smallest values leave min2 == min1.
  always_comb begin
    nxt_min1 = min1;
    nxt_min2 = min2;
    nxt_idx1 = idx1;
    nxt_sgn  = sgn_tot;
    if (upd) begin
      nxt_sgn = sgn_tot ^ sign;
      if (mag < min1) begin
        nxt_min2 = min1;
        nxt_min1 = mag;
        nxt_idx1 = idx;
      end else if (mag < min2) begin
        nxt_min2 = mag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      min1    <= MAXMAG_M;
      min2    <= MAXMAG_M;
      idx1    <= '0;
      sgn_tot <= 1'b0;
    end else begin
      min1    <= nxt_min1;
      min2    <= nxt_min2;
      idx1    <= nxt_idx1;
      sgn_tot <= nxt_sgn;
    end
  end

endmodule

// File: rtl/minsum_cnu.sv
// Serial min-sum check node: collects one row of V2C beats, then replays one C2V per edge.
// Define OFFSET_MINSUM_EN to subtract OFFSET from every C2V magnitude (offset min-sum).
module minsum_cnu
  import ldpc_pkg::*;
#(
  parameter int MAX_DEG = 8,
  parameter int OFFSET  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IN_W-1:0]  i_v2c,
  input  logic             i_v2c_valid,
  input  logic             i_v2c_last,
  output logic             o_v2c_ready,
  output logic [OUT_W-1:0] o_c2v,
  output logic             o_c2v_valid,
  output logic             o_c2v_last,
  input  logic             i_c2v_ready,
  output logic             o_deg_err
);

  localparam int IDX_W = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(MAX_DEG - 1);

`ifdef OFFSET_MINSUM_EN
  localparam bit OFFSET_ON = 1'b1;
`else
  localparam bit OFFSET_ON = 1'b0;
`endif
  localparam mag_t OFF_M = mag_t'(OFFSET_ON ? OFFSET : 0);

  // With a zero offset this is the identity, so plain min-sum shares the same path.
  function automatic mag_t apply_offset(input mag_t m);
    return (m > OFF_M) ? mag_t'(m - OFF_M) : '0;
  endfunction

  cnu_state_t       state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] emit_idx;
  logic [IDX_W-1:0] last_idx;
  logic [MAX_DEG-1:0] sign_arr;

  logic             in_sign;
  mag_t             in_mag;
  logic             accept;
  logic             row_end;
  logic             c2v_hs;
  logic             row_done;
  logic [IDX_W-1:0] next_j;

  mag_t             min1, min2, nxt_min1, nxt_min2;
  logic [IDX_W-1:0] idx1, nxt_idx1;
  logic             sgn_tot, nxt_sgn;

  mag_t             first_mag, next_mag;
  logic             first_sign, next_sign;

  assign in_sign  = i_v2c[IN_W-1];
  assign in_mag   = sat_mag(v2c_t'(i_v2c));
  assign accept   = i_v2c_valid & o_v2c_ready;
  assign row_end  = accept & (i_v2c_last | (cnt == LAST_BEAT));
  assign c2v_hs   = o_c2v_valid & i_c2v_ready;
  assign row_done = c2v_hs & o_c2v_last;
  assign next_j   = emit_idx + 1'b1;

  cnu_min_tracker #(
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (row_done),
    .upd      (accept),
    .mag      (in_mag),
    .sign     (in_sign),
    .idx      (cnt),
    .min1     (min1),
    .min2     (min2),
    .idx1     (idx1),
    .sgn_tot  (sgn_tot),
    .nxt_min1 (nxt_min1),
    .nxt_min2 (nxt_min2),
    .nxt_idx1 (nxt_idx1),
    .nxt_sgn  (nxt_sgn)
  );

  // The first C2V is built from the tracker's next values so it is ready the cycle after the last beat.
  always_comb begin
    first_mag  = (nxt_idx1 == '0) ? nxt_min2 : nxt_min1;
    first_sign = nxt_sgn ^ ((cnt == '0) ? in_sign : sign_arr[0]);
    next_mag   = (next_j == idx1) ? min2 : min1;
    next_sign  = sgn_tot ^ sign_arr[next_j];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      emit_idx    <= '0;
      last_idx    <= '0;
      sign_arr    <= '0;
      o_v2c_ready <= 1'b0;
      o_c2v       <= '0;
      o_c2v_valid <= 1'b0;
      o_c2v_last  <= 1'b0;
      o_deg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          o_v2c_ready <= 1'b1;
          if (accept) begin
            sign_arr[cnt] <= in_sign;
            if (row_end) begin
              state       <= EMIT;
              cnt         <= '0;
              emit_idx    <= '0;
              last_idx    <= cnt;
              o_v2c_ready <= 1'b0;
              o_c2v       <= apply_sign(apply_offset(first_mag), first_sign);
              o_c2v_valid <= 1'b1;
              o_c2v_last  <= (cnt == '0);
              if (!i_v2c_last)
                o_deg_err <= 1'b1;
            end else begin
              state <= COLLECT;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (c2v_hs) begin
            if (o_c2v_last) begin
              state       <= IDLE;
              o_c2v       <= '0;
              o_c2v_valid <= 1'b0;
              o_c2v_last  <= 1'b0;
              o_v2c_ready <= 1'b1;
            end else begin
              emit_idx   <= next_j;
              o_c2v      <= apply_sign(apply_offset(next_mag), next_sign);
              o_c2v_last <= (next_j == last_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
